// File: rtl/tdm_mux4_if.sv
// Channel-side and output-side signals of the 4:1 TDM merger.
// The master drives channel data/valid and output ready; the slave is the merger itself.
interface tdm_mux4_if #(
  parameter int WIDTH = 8
);
  logic [4*WIDTH-1:0] I;
  logic [3:0]         V;
  logic [3:0]         R;
  logic [WIDTH-1:0]   Y;
  logic [1:0]         S;
  logic               Yv;
  logic               Yr;

  modport master (
    output I, V, Yr,
    input  R, Y, S, Yv
  );

  modport slave (
    input  I, V, Yr,
    output R, Y, S, Yv
  );
endinterface

// File: rtl/tdm_mux4.sv
// Round-robin 4:1 time-division merger with a single registered output word.
// Each accepted channel word appears on Y one cycle later, tagged with its channel index on S.
module tdm_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  tdm_mux4_if.slave       bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       s_q, s_d;
  logic             yv_q, yv_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [WIDTH-1:0] chan [4];
  logic             load;
  logic             grant_vld;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             xfer;

  for (genvar k = 0; k < 4; k++) begin : g_chan
    assign chan[k] = bus.I[k*WIDTH +: WIDTH];
  end

  // Output register is free when empty or being drained in this same cycle.
  assign load = ~yv_q | bus.Yr;

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = ptr_q;
    idx       = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (bus.V[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign xfer  = rst_n & load & grant_vld;
  assign bus.R = xfer ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    y_d   = y_q;
    s_d   = s_q;
    yv_d  = yv_q;
    ptr_d = ptr_q;
    if (load) begin
      if (grant_vld) begin
        y_d   = chan[grant];
        s_d   = grant;
        yv_d  = 1'b1;
        ptr_d = grant + 2'd1;
      end else begin
        yv_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      s_q   <= 2'b00;
      yv_q  <= 1'b0;
      ptr_q <= 2'b00;
    end else begin
      y_q   <= y_d;
      s_q   <= s_d;
      yv_q  <= yv_d;
      ptr_q <= ptr_d;
    end
  end

  assign bus.Y  = y_q;
  assign bus.S  = s_q;
  assign bus.Yv = yv_q;

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4: reset, single channel, round-robin, backpressure,
// skip/wrap, idle pointer hold and mid-stream reset, with hand-computed expectations.
module tb_tdm_mux4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  tdm_mux4_if #(.WIDTH(WIDTH)) bus ();

  tdm_mux4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic yv, input logic [1:0] s, input logic [7:0] y);
    chk({tag, ".Yv"}, 32'(bus.Yv), 32'(yv));
    chk({tag, ".S"},  32'(bus.S),  32'(s));
    chk({tag, ".Y"},  32'(bus.Y),  32'(y));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic yr);
    bus.V  = v;
    bus.Yr = yr;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.I  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.V  = 4'b1111;
    bus.Yr = 1'b1;
    rst_n  = 1'b0;

    // reset held two cycles with all channels requesting
    #1;
    chk("rst_R0", 32'(bus.R), 32'h0);
    tick();
    chk("rst_R1", 32'(bus.R), 32'h0);
    chk_out("rst_c1", 1'b0, 2'b00, 8'h00);
    tick();
    chk("rst_R2", 32'(bus.R), 32'h0);
    chk_out("rst_c2", 1'b0, 2'b00, 8'h00);

    // single channel 2
    rst_n = 1'b1;
    bus.I = {8'h13, 8'h5A, 8'h11, 8'h10};
    drive(4'b0100, 1'b1);
    chk("single_R", 32'(bus.R), 32'b0100);
    tick();
    chk_out("single", 1'b1, 2'b10, 8'h5A);

    // idle with load: Yv drops, Y/S hold, ptr stays 3
    drive(4'b0000, 1'b1);
    chk("idle_R", 32'(bus.R), 32'h0);
    tick();
    chk_out("idle", 1'b0, 2'b10, 8'h5A);

    // channel 3 alone: ptr wraps to 0
    bus.I = {8'h13, 8'h12, 8'h11, 8'h10};
    drive(4'b1000, 1'b1);
    chk("wrap_R", 32'(bus.R), 32'b1000);
    tick();
    chk_out("wrap", 1'b1, 2'b11, 8'h13);

    // round robin, full throughput
    drive(4'b1111, 1'b1);
    chk("rr0_R", 32'(bus.R), 32'b0001);
    tick();
    chk_out("rr0", 1'b1, 2'b00, 8'h10);
    chk("rr1_R", 32'(bus.R), 32'b0010);
    tick();
    chk_out("rr1", 1'b1, 2'b01, 8'h11);
    chk("rr2_R", 32'(bus.R), 32'b0100);
    tick();
    chk_out("rr2", 1'b1, 2'b10, 8'h12);
    chk("rr3_R", 32'(bus.R), 32'b1000);
    tick();
    chk_out("rr3", 1'b1, 2'b11, 8'h13);
    chk("rr4_R", 32'(bus.R), 32'b0001);
    tick();
    chk_out("rr4", 1'b1, 2'b00, 8'h10);
    chk("rr5_R", 32'(bus.R), 32'b0010);
    tick();
    chk_out("rr5", 1'b1, 2'b01, 8'h11);

    // backpressure 3 cycles, all channels requesting
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 1'b0);
      chk("bp_R", 32'(bus.R), 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 2'b01, 8'h11);
    end
    drive(4'b1111, 1'b1);
    chk("bp_rel_R", 32'(bus.R), 32'b0100);
    tick();
    chk_out("bp_rel", 1'b1, 2'b10, 8'h12);

    // skip and wrap: grant 1, then V=1010 -> 3, then 1
    drive(4'b0010, 1'b1);
    chk("sk1_R", 32'(bus.R), 32'b0010);
    tick();
    chk_out("sk1", 1'b1, 2'b01, 8'h11);
    drive(4'b1010, 1'b1);
    chk("sk3_R", 32'(bus.R), 32'b1000);
    tick();
    chk_out("sk3", 1'b1, 2'b11, 8'h13);
    chk("sk1b_R", 32'(bus.R), 32'b0010);
    tick();
    chk_out("sk1b", 1'b1, 2'b01, 8'h11);

    // V withdrawn during a stall leaves no retained grant; ptr stays 2
    drive(4'b0001, 1'b0);
    chk("wd_R", 32'(bus.R), 32'h0);
    tick();
    chk_out("wd_hold", 1'b1, 2'b01, 8'h11);
    drive(4'b0000, 1'b1);
    tick();
    chk_out("wd_idle", 1'b0, 2'b01, 8'h11);
    drive(4'b1111, 1'b1);
    chk("wd_ptr_R", 32'(bus.R), 32'b0100);
    tick();
    chk_out("wd_ptr", 1'b1, 2'b10, 8'h12);

    // reset mid-stream while stalled
    rst_n = 1'b0;
    drive(4'b1111, 1'b0);
    chk("mrst_R", 32'(bus.R), 32'h0);
    tick();
    chk_out("mrst", 1'b0, 2'b00, 8'h00);
    rst_n = 1'b1;
    drive(4'b1111, 1'b1);
    chk("mrst_first_R", 32'(bus.R), 32'b0001);
    tick();
    chk_out("mrst_first", 1'b1, 2'b00, 8'h10);

    // empty register accepts even with Yr low
    rst_n = 1'b0;
    drive(4'b0000, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(4'b0010, 1'b0);
    chk("empty_R", 32'(bus.R), 32'b0010);
    tick();
    chk_out("empty", 1'b1, 2'b01, 8'h11);
    chk("empty_stall_R", 32'(bus.R), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
